// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the router output-port arbiter.
// Holds the FSM state encoding, the credit counter width and a one-hot decoder.
package router_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   localparam int CREDIT_W = 4;

   // Index of the set bit in a one-hot vector; 0 when the vector is all-zero.
   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first candidate at or above
// rr_ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
   import router_arb_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int SEL_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] cand,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] win,
   output logic [SEL_W-1:0] win_idx,
   output logic             any
);

   logic [2*N_REQ-1:0] masked;
   logic [2*N_REQ-1:0] first;

   // The upper copy of cand sees every bit, so a candidate below rr_ptr is
   // still found there once the lower copy is masked off.
   assign masked  = {cand, cand} & ({(2*N_REQ){1'b1}} << rr_ptr);
   assign first   = masked & (-masked);
   assign win     = first[N_REQ-1:0] | first[2*N_REQ-1:N_REQ];
   assign win_idx = SEL_W'(onehot_to_idx(32'(win)));
   assign any     = |cand;

endmodule

// File: rtl/router_output_arbiter.sv
// Owner of one shared router output port: wormhole-locks the port to a winning
// channel until its tail flit moves, round-robin between packets, credit flow control.
module router_output_arbiter
   import router_arb_pkg::*;
#(
   parameter  int N_REQ      = 2,
   parameter  int CREDIT_MAX = 4,
   localparam int SEL_W      = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    head,
   input  logic [N_REQ-1:0]    tail,
   input  logic                credit_ret,
   output logic [N_REQ-1:0]    grant,
   output logic [SEL_W-1:0]    out_sel,
   output logic                xfer,
   output logic [CREDIT_W-1:0] credit_cnt,
   output logic                busy,
   output logic                err_credit
);

   localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
   localparam logic [SEL_W-1:0]    SEL_LAST    = SEL_W'(N_REQ - 1);

   arb_state_t          state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [SEL_W-1:0]    out_sel_q, out_sel_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CREDIT_W-1:0] credit_cnt_q, credit_cnt_d;
   logic                err_credit_q, err_credit_d;

   logic [N_REQ-1:0]    cand;
   logic [N_REQ-1:0]    pick_win;
   logic [SEL_W-1:0]    pick_idx;
   logic                pick_any;

   assign cand = req & head;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .cand    (cand),
      .rr_ptr  (rr_ptr_q),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Only the granted channel can move a flit, and never without a credit.
   assign xfer = (|(grant_q & req)) && (credit_cnt_q != '0);

   always_comb begin
      // NOTE: every next-state signal takes its held value first so no path
      // through this block leaves it unassigned (which would infer a latch).
      state_d      = state_q;
      grant_d      = grant_q;
      out_sel_d    = out_sel_q;
      rr_ptr_d     = rr_ptr_q;
      credit_cnt_d = credit_cnt_q;
      err_credit_d = err_credit_q;

      case (state_q)
         IDLE: begin
            if (pick_any && (credit_cnt_q != '0)) begin
               state_d   = LOCK;
               grant_d   = pick_win;
               out_sel_d = pick_idx;
            end
         end
         LOCK: begin
            if (xfer && tail[out_sel_q]) begin
               state_d   = IDLE;
               grant_d   = '0;
               out_sel_d = '0;
               rr_ptr_d  = (out_sel_q == SEL_LAST) ? '0 : out_sel_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A return in the same cycle as a transfer cancels it out.
      if (xfer && !credit_ret) begin
         credit_cnt_d = credit_cnt_q - 1'b1;
      end else if (!xfer && credit_ret) begin
         if (credit_cnt_q == CREDIT_FULL) err_credit_d = 1'b1;
         else                             credit_cnt_d = credit_cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         out_sel_q    <= '0;
         rr_ptr_q     <= '0;
         credit_cnt_q <= CREDIT_FULL;
         err_credit_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         out_sel_q    <= out_sel_d;
         rr_ptr_q     <= rr_ptr_d;
         credit_cnt_q <= credit_cnt_d;
         err_credit_q <= err_credit_d;
      end
   end

   assign grant      = grant_q;
   assign out_sel    = out_sel_q;
   assign credit_cnt = credit_cnt_q;
   assign busy       = (state_q == LOCK);
   assign err_credit = err_credit_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: expected flit transfers go into a
// scoreboard queue and a negedge monitor pops one whenever xfer is seen.
module tb_router_output_arbiter;

   localparam int N_REQ      = 2;
   localparam int CREDIT_MAX = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = '0;
   logic [1:0] head = '0;
   logic [1:0] tail = '0;
   logic       credit_ret = 1'b0;
   logic [1:0] grant;
   logic [0:0] out_sel;
   logic       xfer;
   logic [3:0] credit_cnt;
   logic       busy;
   logic       err_credit;

   router_output_arbiter #(.N_REQ(N_REQ), .CREDIT_MAX(CREDIT_MAX)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .head       (head),
      .tail       (tail),
      .credit_ret (credit_ret),
      .grant      (grant),
      .out_sel    (out_sel),
      .xfer       (xfer),
      .credit_cnt (credit_cnt),
      .busy       (busy),
      .err_credit (err_credit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int sel;
      int cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expect a flit from channel sel in the current cycle with cnt credits on hand.
   task automatic exp_x(input int sel, input int cnt);
      exp_t e;
      e.cyc = cyc;
      e.sel = sel;
      e.cnt = cnt;
      sb_q.push_back(e);
   endtask

   task automatic tick(input logic [1:0] r, input logic [1:0] h, input logic [1:0] t,
                       input logic cr);
      @(posedge clk);
      #1;
      req        = r;
      head       = h;
      tail       = t;
      credit_ret = cr;
   endtask

   task automatic do_reset();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      rst_n      = 1'b0;
      req        = '0;
      head       = '0;
      tail       = '0;
      credit_ret = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_out_sel", 32'(out_sel), 32'd0);
      check("rst_credit", 32'(credit_cnt), 32'd4);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_credit), 32'd0);
      check("rst_xfer", 32'(xfer), 32'd0);
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every observed transfer must match the oldest expectation.
   always @(negedge clk) begin
      if (xfer === 1'b1) begin
         exp_t e;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL xfer_unexpected: got xfer cycle %0d sel %0d cnt %0d, expected none",
                     cyc, out_sel, credit_cnt);
         end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.sel != int'(out_sel) || e.cnt != int'(credit_cnt) ||
                grant !== (2'b01 << e.sel)) begin
               n_bad++;
               $display("FAIL xfer: got cycle %0d sel %0d cnt %0d grant %b, expected cycle %0d sel %0d cnt %0d",
                        cyc, out_sel, credit_cnt, grant, e.cyc, e.sel, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1);
   end

   initial begin
      // 1: both heads at t0, ch0 wins, 3-flit packet, then ch1 after one bubble.
      do_reset();
      tick(2'b11, 2'b11, 2'b00, 1'b0);
      @(negedge clk); check("t1_idle_grant", 32'(grant), 32'd0);
      tick(2'b11, 2'b11, 2'b00, 1'b0); exp_x(0, 4);
      @(negedge clk); check("t1_grant_ch0", 32'(grant), 32'h1);
      check("t1_busy", 32'(busy), 32'd1);
      tick(2'b11, 2'b10, 2'b00, 1'b0); exp_x(0, 3);
      tick(2'b11, 2'b10, 2'b01, 1'b0); exp_x(0, 2);
      tick(2'b10, 2'b10, 2'b00, 1'b0);
      @(negedge clk); check("t1_bubble_grant", 32'(grant), 32'd0);
      check("t1_bubble_busy", 32'(busy), 32'd0);
      check("t1_bubble_credit", 32'(credit_cnt), 32'd1);
      tick(2'b10, 2'b10, 2'b10, 1'b0); exp_x(1, 1);
      @(negedge clk); check("t1_grant_ch1", 32'(grant), 32'h2);
      check("t1_out_sel", 32'(out_sel), 32'd1);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t1_end_grant", 32'(grant), 32'd0);
      check("t1_end_credit", 32'(credit_cnt), 32'd0);

      // 2: 5-flit packet with no returns stalls on flit 5 until one credit comes back.
      do_reset();
      tick(2'b01, 2'b01, 2'b00, 1'b0);
      tick(2'b01, 2'b01, 2'b00, 1'b0); exp_x(0, 4);
      tick(2'b01, 2'b00, 2'b00, 1'b0); exp_x(0, 3);
      tick(2'b01, 2'b00, 2'b00, 1'b0); exp_x(0, 2);
      tick(2'b01, 2'b00, 2'b00, 1'b0); exp_x(0, 1);
      tick(2'b01, 2'b00, 2'b01, 1'b0);
      @(negedge clk); check("t2_credit_zero", 32'(credit_cnt), 32'd0);
      check("t2_stall_grant", 32'(grant), 32'h1);
      tick(2'b01, 2'b00, 2'b01, 1'b1);
      @(negedge clk); check("t2_no_bypass", 32'(credit_cnt), 32'd0);
      tick(2'b01, 2'b00, 2'b01, 1'b0); exp_x(0, 1);
      @(negedge clk); check("t2_credit_back", 32'(credit_cnt), 32'd1);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t2_end_credit", 32'(credit_cnt), 32'd0);
      check("t2_end_busy", 32'(busy), 32'd0);

      // 3: at two credits, transfer plus return every cycle leaves the count alone.
      do_reset();
      tick(2'b01, 2'b01, 2'b00, 1'b0);
      tick(2'b01, 2'b01, 2'b00, 1'b0); exp_x(0, 4);
      tick(2'b01, 2'b00, 2'b00, 1'b0); exp_x(0, 3);
      for (int i = 0; i < 10; i++) begin
         tick(2'b01, 2'b00, 2'b00, 1'b1); exp_x(0, 2);
         @(negedge clk); check("t3_credit_steady", 32'(credit_cnt), 32'd2);
      end
      tick(2'b01, 2'b00, 2'b01, 1'b1); exp_x(0, 2);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t3_end_credit", 32'(credit_cnt), 32'd2);
      check("t3_no_err", 32'(err_credit), 32'd0);
      check("t3_end_grant", 32'(grant), 32'd0);

      // 4: return at full credits saturates and sets the sticky error.
      do_reset();
      tick(2'b00, 2'b00, 2'b00, 1'b1);
      @(negedge clk); check("t4_err_before", 32'(err_credit), 32'd0);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t4_credit_sat", 32'(credit_cnt), 32'd4);
      check("t4_err_set", 32'(err_credit), 32'd1);
      repeat (3) tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t4_err_sticky", 32'(err_credit), 32'd1);

      // 5: ch1 holds the lock through a 3-cycle req gap; ch0 waits until after the tail.
      do_reset();
      tick(2'b10, 2'b10, 2'b00, 1'b0);
      tick(2'b10, 2'b10, 2'b00, 1'b0); exp_x(1, 4);
      @(negedge clk); check("t5_grant_ch1", 32'(grant), 32'h2);
      for (int i = 0; i < 3; i++) begin
         tick(2'b01, 2'b01, 2'b00, 1'b0);
         @(negedge clk); check("t5_hold_grant", 32'(grant), 32'h2);
         check("t5_hold_busy", 32'(busy), 32'd1);
      end
      tick(2'b11, 2'b01, 2'b10, 1'b0); exp_x(1, 3);
      tick(2'b01, 2'b01, 2'b00, 1'b0);
      @(negedge clk); check("t5_bubble_grant", 32'(grant), 32'd0);
      tick(2'b01, 2'b01, 2'b01, 1'b0); exp_x(0, 2);
      @(negedge clk); check("t5_grant_ch0", 32'(grant), 32'h1);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t5_end_credit", 32'(credit_cnt), 32'd1);

      // 6: async reset mid-packet with rr_ptr=1 and one credit left.
      do_reset();
      tick(2'b01, 2'b01, 2'b01, 1'b0);
      tick(2'b01, 2'b01, 2'b01, 1'b0); exp_x(0, 4);
      tick(2'b01, 2'b01, 2'b00, 1'b0);
      tick(2'b01, 2'b01, 2'b00, 1'b0); exp_x(0, 3);
      tick(2'b01, 2'b00, 2'b00, 1'b0); exp_x(0, 2);
      tick(2'b01, 2'b00, 2'b00, 1'b0);
      check("t6_pre_credit", 32'(credit_cnt), 32'd1);
      check("t6_pre_grant", 32'(grant), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_grant", 32'(grant), 32'd0);
      check("t6_async_xfer", 32'(xfer), 32'd0);
      check("t6_async_credit", 32'(credit_cnt), 32'd4);
      check("t6_async_busy", 32'(busy), 32'd0);
      do_reset();
      tick(2'b11, 2'b11, 2'b00, 1'b0);
      @(negedge clk); check("t6_rel_idle", 32'(grant), 32'd0);
      tick(2'b11, 2'b11, 2'b01, 1'b0); exp_x(0, 4);
      @(negedge clk); check("t6_rel_grant_ch0", 32'(grant), 32'h1);
      tick(2'b10, 2'b10, 2'b10, 1'b0);
      @(negedge clk); check("t6_bubble_grant", 32'(grant), 32'd0);
      tick(2'b10, 2'b10, 2'b10, 1'b0); exp_x(1, 3);
      @(negedge clk); check("t6_grant_ch1", 32'(grant), 32'h2);
      tick(2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk); check("t6_end_credit", 32'(credit_cnt), 32'd2);

      check("sb_final_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
